branch_resolve: RTL and testbench

Resolves conditional branches against the registered N/Z/V flags produced by the ALU. It is the consumer end of the flag interface. It sits alongside the ALU in the EX stage:
- evaluates the 3-bit branch condition and computes the target;
- issues a one-cycle PC redirect and a multi-cycle pipeline flush;
- drives `prev_br_ctrl` back to the ALU so that squashed instructions cannot corrupt the flags;
- interlocks when a flag-setting instruction is still in flight;
- keeps saturating branch and taken counters for performance reporting.

---
 rtl/branch_resolve.sv | 119 +++++++++++
 tb/tb_branch_resolve.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
`default_nettype none
// branch_resolve: evaluates branch conditions on the ALU flags, redirects fetch,
// holds a multi-cycle flush and keeps saturating branch/taken counters.
module branch_resolve #(
  parameter int PC_W         = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_valid,
  input  logic [2:0]      br_cond,
  input  logic [PC_W-1:0] br_pc_next,
  input  logic [8:0]      br_offset,
  input  logic            flag_N,
  input  logic            flag_Z,
  input  logic            flag_V,
  input  logic            flag_pending,
  output logic            br_ready,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic            prev_br_ctrl,
  output logic [15:0]     br_count,
  output logic [15:0]     taken_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FLUSH} state_t;

  localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_CYCLES);
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

  state_t          state_q;
  logic [3:0]      flush_cnt_q;
  logic            redirect_q;
  logic            flush_q;
  logic [PC_W-1:0] redirect_pc_q;
  logic [PC_W-1:0] redirect_pc_d;
  logic [15:0]     br_cnt_q;
  logic [15:0]     taken_cnt_q;
  logic            taken_d;

  always_comb begin
    taken_d = 1'b1;
    case (br_cond)
      3'b000:  taken_d = !flag_Z;
      3'b001:  taken_d = flag_Z;
      3'b010:  taken_d = !flag_Z && !flag_N;
      3'b011:  taken_d = flag_N;
      3'b100:  taken_d = flag_Z || !flag_N;
      3'b101:  taken_d = flag_N || flag_Z;
      3'b110:  taken_d = flag_V;
      default: taken_d = 1'b1;
    endcase
  end

  // Word offset is sign-extended and added modulo 2^PC_W.
  assign redirect_pc_d = br_pc_next + {{(PC_W-9){br_offset[8]}}, br_offset};

  // Held low during reset so no branch appears accepted while state is being cleared.
  assign br_ready = !rst && (state_q != S_FLUSH) && br_valid && !flag_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      flush_cnt_q   <= 4'd0;
      redirect_q    <= 1'b0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      br_cnt_q      <= 16'd0;
      taken_cnt_q   <= 16'd0;
    end else begin
      redirect_q <= 1'b0;
      case (state_q)
        S_IDLE, S_WAIT: begin
          if (br_valid && flag_pending) begin
            state_q <= S_WAIT;
          end else if (br_valid) begin
            if (br_cnt_q != CNT_MAX) br_cnt_q <= br_cnt_q + 16'd1;
            if (taken_d) begin
              if (taken_cnt_q != CNT_MAX) taken_cnt_q <= taken_cnt_q + 16'd1;
              redirect_pc_q <= redirect_pc_d;
              redirect_q    <= 1'b1;
              flush_q       <= 1'b1;
              flush_cnt_q   <= FLUSH_LOAD;
              state_q       <= S_FLUSH;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_FLUSH: begin
          // Counter value 1 marks the last flush cycle.
          if (flush_cnt_q <= 4'd1) begin
            flush_cnt_q <= 4'd0;
            flush_q     <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
          end
        end
        default: begin
          flush_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign redirect     = redirect_q;
  assign redirect_pc  = redirect_pc_q;
  assign flush        = flush_q;
  assign prev_br_ctrl = flush_q;
  assign br_count     = br_cnt_q;
  assign taken_count  = taken_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// tb_branch_resolve: directed stimulus with a redirect scoreboard and inline checks.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic [15:0] br_pc_next;
  logic [8:0]  br_offset;
  logic        flag_N, flag_Z, flag_V, flag_pending;
  logic        br_ready, redirect, flush, prev_br_ctrl;
  logic [15:0] redirect_pc, br_count, taken_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_br, exp_tk;

  always #5 clk = ~clk;

  branch_resolve #(.PC_W(16), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_cond(br_cond),
    .br_pc_next(br_pc_next), .br_offset(br_offset),
    .flag_N(flag_N), .flag_Z(flag_Z), .flag_V(flag_V), .flag_pending(flag_pending),
    .br_ready(br_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .flush(flush), .prev_br_ctrl(prev_br_ctrl),
    .br_count(br_count), .taken_count(taken_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every redirect pulse must match the oldest expected target.
  always @(negedge clk) begin
    if (redirect === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_redirect: got pc %h expected no redirect", redirect_pc);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (redirect_pc !== e) begin
          errors++;
          $display("FAIL redirect_pc: got %h expected %h", redirect_pc, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input string name);
    chk({name, "_br_count"}, {16'd0, br_count}, {16'd0, exp_br});
    chk({name, "_taken_count"}, {16'd0, taken_count}, {16'd0, exp_tk});
  endtask

  // Not-taken vectors: {cond, N, Z, V}
  logic [5:0] nt_tab [6] = '{
    {3'b001, 3'b100}, {3'b010, 3'b100}, {3'b100, 3'b100},
    {3'b110, 3'b100}, {3'b101, 3'b000}, {3'b000, 3'b010}
  };

  initial begin
    rst = 1'b1; br_valid = 1'b1; br_cond = 3'b111; br_pc_next = 16'h0100;
    br_offset = 9'h004; flag_N = 0; flag_Z = 0; flag_V = 0; flag_pending = 0;
    exp_br = 0; exp_tk = 0;

    // 1. reset with a pending uncond branch
    tick(); tick();
    chk("rst_ready", {31'd0, br_ready}, 0);
    chk("rst_redirect", {31'd0, redirect}, 0);
    chk("rst_flush", {31'd0, flush}, 0);
    chk("rst_prev", {31'd0, prev_br_ctrl}, 0);
    chk("rst_pc", {16'd0, redirect_pc}, 0);
    chk_counts("rst");
    rst = 1'b0;
    #1 chk("t1_ready", {31'd0, br_ready}, 1);
    exp_q.push_back(16'h0104); exp_br++; exp_tk++;
    tick(); br_valid = 0;
    chk("t1_redirect", {31'd0, redirect}, 1);
    chk("t1_flush1", {31'd0, flush}, 1);
    chk_counts("t1");
    tick();
    chk("t1_redirect_off", {31'd0, redirect}, 0);
    chk("t1_flush2", {31'd0, flush}, 1);
    tick();
    chk("t1_flush_off", {31'd0, flush}, 0);

    // 2. eq taken with negative offset
    flag_Z = 1; br_cond = 3'b001; br_pc_next = 16'h0010; br_offset = 9'h1FE; br_valid = 1;
    #1 chk("t2_ready", {31'd0, br_ready}, 1);
    exp_q.push_back(16'h000E); exp_br++; exp_tk++;
    tick(); br_valid = 0;
    chk("t2_redirect", {31'd0, redirect}, 1);
    chk("t2_prev1", {31'd0, prev_br_ctrl}, 1);
    chk_counts("t2");
    tick();
    chk("t2_redirect_off", {31'd0, redirect}, 0);
    chk("t2_flush2", {31'd0, flush}, 1);
    chk("t2_prev2", {31'd0, prev_br_ctrl}, 1);
    tick();
    chk("t2_flush_off", {31'd0, flush}, 0);
    chk("t2_prev_off", {31'd0, prev_br_ctrl}, 0);
    chk("t2_pc_hold", {16'd0, redirect_pc}, 32'h000E);

    // 3. gt not taken, followed immediately by more branches
    flag_N = 1; flag_Z = 0; br_cond = 3'b010; br_valid = 1;
    #1 chk("t3_ready", {31'd0, br_ready}, 1);
    exp_br++;
    tick();
    chk("t3_redirect", {31'd0, redirect}, 0);
    chk("t3_flush", {31'd0, flush}, 0);
    chk_counts("t3");
    foreach (nt_tab[i]) begin
      {br_cond, flag_N, flag_Z, flag_V} = nt_tab[i];
      #1 chk($sformatf("t3_nt%0d_ready", i), {31'd0, br_ready}, 1);
      exp_br++;
      tick();
      chk($sformatf("t3_nt%0d_flush", i), {31'd0, flush}, 0);
    end
    chk_counts("t3_nt");
    flag_N = 1; flag_Z = 0; flag_V = 0;
    br_cond = 3'b011; br_pc_next = 16'h0200; br_offset = 9'h0FF;
    #1 chk("t3_lt_ready", {31'd0, br_ready}, 1);
    exp_q.push_back(16'h02FF); exp_br++; exp_tk++;
    tick(); br_valid = 0;
    chk("t3_lt_redirect", {31'd0, redirect}, 1);
    tick(); tick();

    // 4. flag hazard for two cycles, Z flips while pending
    flag_N = 0; flag_Z = 0; flag_pending = 1;
    br_cond = 3'b001; br_pc_next = 16'h1000; br_offset = 9'h010; br_valid = 1;
    #1 chk("t4_stall1", {31'd0, br_ready}, 0);
    tick(); flag_Z = 1;
    #1 chk("t4_stall2", {31'd0, br_ready}, 0);
    chk("t4_no_redirect", {31'd0, redirect}, 0);
    tick(); flag_pending = 0;
    #1 chk("t4_ready", {31'd0, br_ready}, 1);
    exp_q.push_back(16'h1010); exp_br++; exp_tk++;
    tick(); br_valid = 0;
    chk("t4_redirect", {31'd0, redirect}, 1);
    chk_counts("t4");
    tick(); tick();

    // 5. wrap target, ignored branch during flush, reset mid-flush
    br_cond = 3'b111; br_pc_next = 16'hFFFF; br_offset = 9'h005; br_valid = 1;
    #1 chk("t5_ready", {31'd0, br_ready}, 1);
    exp_q.push_back(16'h0004); exp_br++; exp_tk++;
    tick();
    br_pc_next = 16'h3000;
    #1 chk("t5_flush_ready1", {31'd0, br_ready}, 0);
    tick();
    chk("t5_flush_ready2", {31'd0, br_ready}, 0);
    chk("t5_flush2", {31'd0, flush}, 1);
    chk_counts("t5_ignored");
    rst = 1; br_valid = 0;
    tick();
    chk("t5_rst_flush", {31'd0, flush}, 0);
    chk("t5_rst_prev", {31'd0, prev_br_ctrl}, 0);
    chk("t5_rst_pc", {16'd0, redirect_pc}, 0);
    exp_br = 0; exp_tk = 0;
    chk_counts("t5_rst");
    rst = 0;
    tick();

    // 6. saturation from a preloaded count
    force dut.br_cnt_q = 16'hFFFE;
    force dut.taken_cnt_q = 16'hFFFE;
    #1;
    release dut.br_cnt_q;
    release dut.taken_cnt_q;
    exp_br = 16'hFFFE; exp_tk = 16'hFFFE;
    br_cond = 3'b111; br_pc_next = 16'h0040; br_offset = 9'h000;
    for (int k = 0; k < 3; k++) begin
      br_valid = 1;
      #1 chk($sformatf("t6_ready%0d", k), {31'd0, br_ready}, 1);
      exp_q.push_back(16'h0040);
      exp_br = 16'hFFFF; exp_tk = 16'hFFFF;
      tick(); br_valid = 0;
      chk_counts($sformatf("t6_sat%0d", k));
      tick(); tick();
    end

    tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
